// File: rtl/median_frame_writer_pkg.sv
// Shared definitions for the median filter result path: default geometry,
// writer FSM encoding and the border test used by writer and window generator.
package median_frame_writer_pkg;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Border = outermost row or column; the 3x3 window has no full neighbourhood there.
  function automatic logic is_border(input int row, input int col, input int w, input int h);
    return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
  endfunction

endpackage

// File: rtl/median_frame_writer_if.sv
// Result stream from the median core plus the frame RAM write port.
interface median_frame_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17
);
  logic              res_valid_i;
  logic [DATA_W-1:0] res_data_i;
  logic              res_ready_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;

  modport master (
    input  res_valid_i, res_data_i,
    output res_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    output res_valid_i, res_data_i,
    input  res_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/median_frame_writer_raster_counter.sv
// Raster position tracker: col/row/linear address, advancing one pixel per inc.
module raster_counter #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int COL_W  = $clog2(IMG_W),
  parameter int ROW_W  = $clog2(IMG_H)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr,
  input  logic              inc,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last_pix
);

  assign last_col = (col == COL_W'(IMG_W - 1));
  assign last_pix = last_col && (row == ROW_W'(IMG_H - 1));

  // Wraps to the origin after the final pixel so the next frame starts clean.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (inc) begin
      addr <= last_pix ? '0 : addr + ADDR_W'(1);
      if (last_col) begin
        col <= '0;
        row <= last_pix ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/median_frame_writer.sv
// Writes one IMG_W x IMG_H frame in raster order: border pixels get BORDER_VAL,
// interior pixels take filter results from the upstream stream.
module median_frame_writer
  import median_frame_writer_pkg::*;
#(
  parameter int                IMG_W      = IMG_W_DEF,
  parameter int                IMG_H      = IMG_H_DEF,
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 17,
  parameter logic [DATA_W-1:0] BORDER_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  median_frame_writer_if.master bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [ADDR_W-1:0]   addr;
  logic                last_col, last_pix, frame_end;
  logic                border, beat, clr, tail_q;

  assign clr       = (state_q == ST_IDLE) && start_i;
  assign border    = is_border(int'(row), int'(col), IMG_W, IMG_H);
  assign frame_end = last_col && last_pix;

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (clr),
    .inc     (beat),
    .col     (col),
    .row     (row),
    .addr    (addr),
    .last_col(last_col),
    .last_pix(last_pix)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // RUN lingers one cycle after the final beat (tail_q) so busy_o covers the last write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (tail_q)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.res_ready_o = 1'b0;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    beat            = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        busy_o          = 1'b1;
        bus.res_ready_o = !tail_q && !border;
        beat            = !tail_q && (border || bus.res_valid_i);
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.wr_en_o   <= 1'b0;
      bus.wr_addr_o <= '0;
      bus.wr_data_o <= '0;
      tail_q        <= 1'b0;
      ovf_o         <= 1'b0;
    end else begin
      bus.wr_en_o <= beat;
      if (beat) begin
        bus.wr_addr_o <= addr;
        bus.wr_data_o <= border ? BORDER_VAL : bus.res_data_i;
      end
      if (clr)                     tail_q <= 1'b0;
      else if (beat && frame_end)  tail_q <= 1'b1;
      // A result offered while idle has nowhere to go; flag it until the next frame.
      if (clr)                                          ovf_o <= 1'b0;
      else if ((state_q == ST_IDLE) && bus.res_valid_i) ovf_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_median_frame_writer.sv
// Randomized bench for median_frame_writer: a 5x4 and a 320x240 instance
// checked against a frame-image reference model.
module tb_median_frame_writer;
  localparam int SW = 5, SH = 4, BW = 320, BH = 240;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, s_start, valid, sel;
  logic [7:0] data;
  logic       s_busy, s_done, s_ovf, b_busy, b_done, b_ovf;
  logic       m_wr_en, m_ready, m_busy, m_done, m_ovf;
  logic [16:0] m_addr;
  logic [7:0]  m_data;

  median_frame_writer_if #(.DATA_W(8), .ADDR_W(17)) s_if ();
  median_frame_writer_if #(.DATA_W(8), .ADDR_W(17)) b_if ();

  assign s_if.res_valid_i = valid;
  assign s_if.res_data_i  = data;
  assign b_if.res_valid_i = valid;
  assign b_if.res_data_i  = data;

  median_frame_writer #(.IMG_W(SW), .IMG_H(SH), .DATA_W(8), .ADDR_W(17), .BORDER_VAL(8'd0)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(s_start && !sel), .bus(s_if),
    .busy_o(s_busy), .done_o(s_done), .ovf_o(s_ovf));

  median_frame_writer #(.IMG_W(BW), .IMG_H(BH), .DATA_W(8), .ADDR_W(17), .BORDER_VAL(8'd0)) u_big (
    .clk_i(clk), .rst_i(rst), .start_i(s_start && sel), .bus(b_if),
    .busy_o(b_busy), .done_o(b_done), .ovf_o(b_ovf));

  assign m_wr_en = sel ? b_if.wr_en_o     : s_if.wr_en_o;
  assign m_addr  = sel ? b_if.wr_addr_o   : s_if.wr_addr_o;
  assign m_data  = sel ? b_if.wr_data_o   : s_if.wr_data_o;
  assign m_ready = sel ? b_if.res_ready_o : s_if.res_ready_o;
  assign m_busy  = sel ? b_busy : s_busy;
  assign m_done  = sel ? b_done : s_done;
  assign m_ovf   = sel ? b_ovf  : s_ovf;

  int n_chk, n_err, cyc, k, vmode, W, H;
  int src[$];
  int w_addr[$], w_data[$], w_cyc[$];
  int busy_bad, done_n, done_at;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wd(input int i);
    return (i < w_data.size()) ? w_data[i] : -1;
  endfunction

  function automatic int span();
    return (w_cyc.size() > 0) ? (w_cyc[$] - w_cyc[0] + 1) : 0;
  endfunction

  task automatic drive();
    case (vmode)
      1: valid = 1'b1;
      2: valid = (cyc % 3 == 0);
      3: valid = 1'($urandom_range(0, 1));
      default: ;
    endcase
    data = (k < src.size()) ? 8'(src[k]) : 8'h00;
  endtask

  // One clock: observe mid-cycle, then advance stimulus just after the edge.
  task automatic step();
    @(negedge clk);
    if (m_wr_en) begin
      w_addr.push_back(int'(m_addr));
      w_data.push_back(int'(m_data));
      w_cyc.push_back(cyc);
      if (!m_busy) busy_bad++;
    end
    if (m_done) done_n++;
    if (valid && m_ready) k++;
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic clear_logs();
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    busy_bad = 0; done_n = 0; done_at = -1; k = 0;
  endtask

  task automatic fill_src(input bit ramp);
    src.delete();
    for (int i = 0; i < (W - 2) * (H - 2) + 4; i++)
      src.push_back(ramp ? ((i + 1) & 255) : int'($urandom_range(1, 255)));
  endtask

  task automatic start_frame(input int mode);
    vmode = 0; valid = 1'b0; data = 8'(src[0]);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("busy_after_start", m_busy, 1);
    vmode = mode;
    drive();
  endtask

  task automatic run_to_done(input string tag, input int maxc, input int ill_addr);
    int  n = 0;
    bit  pulsed = 1'b0;
    while (!m_done && n < maxc) begin
      step();
      n++;
      s_start = 1'b0;
      if (ill_addr >= 0 && !pulsed && m_wr_en && int'(m_addr) == ill_addr) begin
        s_start = 1'b1;
        pulsed  = 1'b1;
      end
    end
    chk({tag, " done_seen"}, m_done, 1);
    chk({tag, " busy_in_done"}, m_busy, 0);
    done_at = cyc;
    vmode = 0; valid = 1'b0; s_start = 1'b0;
  endtask

  // Reference image: border everywhere, interior filled by results in raster order.
  task automatic check_frame(input string tag);
    int img[];
    int n = W * H, ni = 0, bad_a = 0, bad_d = 0;
    img = new[n];
    foreach (img[i]) img[i] = 0;
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        img[r * W + c] = src[ni];
        ni++;
      end
    chk({tag, " n_writes"}, w_addr.size(), n);
    for (int i = 0; i < w_addr.size(); i++) begin
      if (w_addr[i] != i) bad_a++;
      if (i < n && w_data[i] != img[i]) bad_d++;
    end
    chk({tag, " addr_seq_bad"}, bad_a, 0);
    chk({tag, " data_bad"}, bad_d, 0);
    chk({tag, " consumed"}, k, ni);
    chk({tag, " done_gap"}, done_at - ((w_cyc.size() > 0) ? w_cyc[$] : -100), 1);
    chk({tag, " wr_outside_busy"}, busy_bad, 0);
  endtask

  task automatic idle_tail(input string tag);
    repeat (3) step();
    chk({tag, " done_once"}, done_n, 1);
    chk({tag, " no_extra_wr"}, w_addr.size(), W * H);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; k = 0; vmode = 0;
    valid = 1'b0; data = 8'h00; s_start = 1'b0; sel = 1'b0; rst = 1'b1;
    W = SW; H = SH;
    fill_src(1'b1);
    clear_logs();
    @(posedge clk); #1;
    step();

    // Reset state
    chk("rst wr_en", m_wr_en, 0);
    chk("rst wr_addr", m_addr, 0);
    chk("rst wr_data", m_data, 0);
    chk("rst busy", m_busy, 0);
    chk("rst done", m_done, 0);
    chk("rst ovf", m_ovf, 0);
    chk("rst ready", m_ready, 0);
    rst = 1'b0;
    repeat (3) step();
    chk("rst no_write", w_addr.size(), 0);

    // Valid stuck high, ramp data
    clear_logs(); fill_src(1'b1);
    start_frame(1);
    run_to_done("t2", 200, -1);
    check_frame("t2");
    chk("t2 a5", wd(5), 0);
    chk("t2 a6", wd(6), 1);
    chk("t2 a9", wd(9), 0);
    chk("t2 a13", wd(13), 6);
    chk("t2 contiguous", span(), SW * SH);
    idle_tail("t2");

    // Valid every third cycle: same image, border beats don't wait
    clear_logs(); fill_src(1'b1);
    start_frame(2);
    run_to_done("t3", 400, -1);
    check_frame("t3");
    chk("t3 a13", wd(13), 6);
    chk("t3 border_burst", (w_cyc.size() > 5) ? w_cyc[5] - w_cyc[0] : -1, 5);
    idle_tail("t3");

    // Illegal starts: mid-frame and during DONE
    clear_logs(); fill_src(1'b1);
    start_frame(1);
    run_to_done("t4a", 200, 7);
    check_frame("t4a");
    s_start = 1'b1;
    step();
    chk("t4 start_in_done busy", m_busy, 0);
    chk("t4 start_in_done wr", m_wr_en, 0);
    clear_logs(); fill_src(1'b0);
    start_frame(1);
    run_to_done("t4b", 200, -1);
    check_frame("t4b");
    idle_tail("t4b");

    // Reset on the beat for addr 9
    clear_logs(); fill_src(1'b1);
    start_frame(1);
    for (int n = 0; n < 100; n++) begin
      if (m_wr_en && int'(m_addr) == 8) break;
      step();
    end
    rst = 1'b1; vmode = 0; valid = 1'b0;
    step();
    chk("t5 wr_en_after_rst", m_wr_en, 0);
    chk("t5 busy_after_rst", m_busy, 0);
    rst = 1'b0;
    repeat (4) step();
    chk("t5 writes_before_rst", w_addr.size(), 9);
    clear_logs(); fill_src(1'b1);
    start_frame(1);
    run_to_done("t5b", 200, -1);
    check_frame("t5b");
    idle_tail("t5b");

    // Result offered while idle
    clear_logs();
    valid = 1'b1;
    step(); step();
    chk("t6 ovf_set", m_ovf, 1);
    chk("t6 ready_idle", m_ready, 0);
    valid = 1'b0;
    step();
    chk("t6 ovf_sticky", m_ovf, 1);
    chk("t6 no_write", w_addr.size(), 0);
    fill_src(1'b0);
    start_frame(3);
    chk("t6 ovf_cleared", m_ovf, 0);
    run_to_done("t6", 600, -1);
    check_frame("t6");
    idle_tail("t6");

    // Default geometry, valid stuck high
    sel = 1'b1; W = BW; H = BH;
    clear_logs(); fill_src(1'b0);
    start_frame(1);
    run_to_done("t7", 80000, -1);
    check_frame("t7");
    chk("t7 a321", wd(321), src[0]);
    chk("t7 a76478", wd(76478), src[75683]);
    chk("t7 contiguous", span(), BW * BH);
    idle_tail("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
